// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM encoding and saved-store record for the MEM-stage access unit.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    // Sub-word store captured in cycle 0 of a read-modify-write
    typedef struct packed {
        logic [1:0]  lane;
        logic [1:0]  size;
        logic [15:0] data;
    } sav_t;

    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b11) || (size == SZ_H && a[0]) || (size == SZ_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Replaces the addressed byte or halfword lane of a memory word with new store data.
module lane_merge
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        if (size == SZ_H) begin
            if (lane[1]) merged[31:16] = new_data;
            else         merged[15:0]  = new_data;
        end else begin
            case (lane)
                2'd0:    merged[7:0]   = new_data[7:0];
                2'd1:    merged[15:8]  = new_data[7:0];
                2'd2:    merged[23:16] = new_data[7:0];
                default: merged[31:24] = new_data[7:0];
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-only data memory: byte/half/word loads, word stores,
// and sub-word stores as a 2-cycle read-modify-write with stall.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic [31:0]      rdata,
    output logic             done,
    output logic             stall,
    output logic             misalign,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_dmwr,
    input  logic [31:0]      dm_dout
);

    state_t           state, state_nx;
    logic [31:0]      old_word;
    logic [DM_AW-1:0] sav_addr;
    sav_t             sav;
    logic             cap;
    logic             go;
    logic             fault;
    logic [31:0]      merged;
    logic [31:0]      shifted;
    logic [15:0]      half;
    logic [31:0]      ld_data;

    // Gate requests with reset so nothing reaches memory while reset is held
    assign go    = req_valid & rst;
    assign fault = is_fault(req_size, req_addr[1:0]);

    lane_merge u_merge (
        .old_word (old_word),
        .new_data (sav.data),
        .lane     (sav.lane),
        .size     (sav.size),
        .merged   (merged)
    );

    assign shifted = dm_dout >> {req_addr[1:0], 3'b000};
    assign half    = req_addr[1] ? dm_dout[31:16] : dm_dout[15:0];

    always_comb begin
        case (req_size)
            SZ_B:    ld_data = {{24{req_sign & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{req_sign & half[15]}}, half};
            default: ld_data = dm_dout;
        endcase
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        dm_dmwr  = 1'b0;
        rdata    = '0;
        dm_din   = '0;
        dm_addr  = req_addr[DM_AW+1:2];
        cap      = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (fault) begin
                        misalign = 1'b1;
                        done     = 1'b1;
                    end else if (!req_we) begin
                        rdata = ld_data;
                        done  = 1'b1;
                    end else if (req_size == SZ_W) begin
                        dm_din  = req_wdata;
                        dm_dmwr = 1'b1;
                        done    = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        cap      = 1'b1;
                        state_nx = S_RMW;
                    end
                end
            end
            S_RMW: begin
                dm_addr  = sav_addr;
                dm_din   = merged;
                dm_dmwr  = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            old_word <= '0;
            sav_addr <= '0;
            sav      <= '0;
        end else begin
            state <= state_nx;
            if (cap) begin
                old_word <= dm_dout;
                sav_addr <= req_addr[DM_AW+1:2];
                sav.lane <= req_addr[1:0];
                sav.size <= req_size;
                sav.data <= req_wdata[15:0];
            end
        end
    end

endmodule
